// File: rtl/gate_bank_fault_prob.sv
// gate_bank_fault_prob: bank of probabilistic fault gates with per-channel trigger queues and LFSRs
module gate_bank_fault_prob #(
  parameter int NUM_CH = 4,
  parameter int INPUT_COUNT = 2,
  parameter int OUTPUT_COUNT = 2,
  parameter int PEND_MAX = 3,
  parameter logic [11:0] RAND_SEED = 12'hAAA
) (
  input  logic clk,
  input  logic reset,
  input  logic logic_reset,
  input  logic eval_en,
  input  logic [NUM_CH*INPUT_COUNT-1:0] in,
  input  logic [NUM_CH-1:0] fault_in,
  output logic [NUM_CH*OUTPUT_COUNT-1:0] out,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow
);
  localparam int QW = $clog2(PEND_MAX + 1);
  localparam int KW = $clog2(INPUT_COUNT + 1);
  localparam int CW = 12 + KW;
  localparam logic [11:0] TAPS = 12'hE08;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [11:0] S = RAND_SEED ^ 12'((g * 12'h9E3) % 4096);
    localparam logic [11:0] SEED = (S == 12'h000) ? 12'h001 : S;
    logic [QW-1:0] q_q, q_d;
    logic [11:0] lfsr_q, lfsr_d;
    logic fire_q, fire_d, ovf_q, ovf_d;
    logic [KW-1:0] k;
    logic draw, inc, full, hit;
    always_comb begin
      k = '0;
      for (int i = 0; i < INPUT_COUNT; i++) k = k + KW'(in[g*INPUT_COUNT+i]);
      draw = eval_en & (q_q != '0);
      inc = fault_in[g];
      full = q_q == QW'(PEND_MAX);
      hit = (CW'(lfsr_q) * CW'(INPUT_COUNT)) < (CW'(k) << 12);
      q_d = logic_reset ? '0
          : (inc & ~draw & ~full) ? q_q + QW'(1)
          : (~inc & draw) ? q_q - QW'(1) : q_q;
      ovf_d = ~logic_reset & (ovf_q | (inc & ~draw & full));
      fire_d = ~logic_reset & draw & hit;
      lfsr_d = (~logic_reset & draw) ? ({1'b0, lfsr_q[11:1]} ^ (lfsr_q[0] ? TAPS : 12'h000)) : lfsr_q;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        q_q <= '0;
        lfsr_q <= SEED;
        fire_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        q_q <= q_d;
        lfsr_q <= lfsr_d;
        fire_q <= fire_d;
        ovf_q <= ovf_d;
      end
    assign out[g*OUTPUT_COUNT +: OUTPUT_COUNT] = {OUTPUT_COUNT{fire_q}};
    assign pending[g] = q_q != '0;
    assign overflow[g] = ovf_q;
  end
endmodule

// File: tb/tb_gate_bank_fault_prob.sv
// tb_gate_bank_fault_prob: directed and random checks of the fault gate bank against a behavioural model
module tb_gate_bank_fault_prob;
  logic clk = 1'b0;
  logic reset, logic_reset, eval_en;
  logic [15:0] lamps;
  logic [3:0] fault_in;
  logic [7:0] out;
  logic [3:0] pending, overflow;
  int errors = 0, checks = 0, fires0 = 0;
  int mq[4];
  bit movf[4], mout[4];
  logic [11:0] ml[4];

  always #5 clk = ~clk;

  gate_bank_fault_prob #(.NUM_CH(4), .INPUT_COUNT(4), .OUTPUT_COUNT(2), .PEND_MAX(3), .RAND_SEED(12'hAAA)) dut (
    .clk(clk), .reset(reset), .logic_reset(logic_reset), .eval_en(eval_en),
    .in(lamps), .fault_in(fault_in), .out(out), .pending(pending), .overflow(overflow)
  );

  function automatic logic [11:0] seed_of(int c);
    logic [11:0] s;
    s = 12'hAAA ^ 12'((c * 'h9E3) % 4096);
    return (s == 0) ? 12'h001 : s;
  endfunction

  function automatic logic [11:0] lstep(logic [11:0] r);
    return r[0] ? ((r >> 1) ^ 12'hE08) : (r >> 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      mq[c] = 0; movf[c] = 0; mout[c] = 0; ml[c] = seed_of(c);
    end
  endtask

  task automatic model_clk();
    for (int c = 0; c < 4; c++) begin
      int k;
      bit draw, inc, fire;
      if (logic_reset) begin
        mq[c] = 0; mout[c] = 0; movf[c] = 0;
      end else begin
        k = $countones(lamps[c*4 +: 4]);
        draw = eval_en && mq[c] > 0;
        inc = fault_in[c];
        fire = (int'(ml[c]) * 4) < (k * 4096);
        mout[c] = draw && fire;
        if (draw) ml[c] = lstep(ml[c]);
        if (inc && !draw) begin
          if (mq[c] == 3) movf[c] = 1; else mq[c]++;
        end else if (draw && !inc) mq[c]--;
      end
    end
  endtask

  task automatic check(string tag);
    logic [7:0] eo;
    logic [3:0] ep, ev;
    for (int c = 0; c < 4; c++) begin
      eo[c*2 +: 2] = {2{mout[c]}};
      ep[c] = mq[c] != 0;
      ev[c] = movf[c];
    end
    checks += 3;
    assert (out === eo) else begin errors++; $error("FAIL %s out=%h expected=%h", tag, out, eo); end
    assert (pending === ep) else begin errors++; $error("FAIL %s pending=%h expected=%h", tag, pending, ep); end
    assert (overflow === ev) else begin errors++; $error("FAIL %s overflow=%h expected=%h", tag, overflow, ev); end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_clk();
    #1;
    if (out[0]) fires0++;
    check(tag);
  endtask

  initial begin
    reset = 1'b1; logic_reset = 1'b0; eval_en = 1'b0; lamps = '0; fault_in = '0;
    model_reset();
    #12;
    check("reset");
    reset = 1'b0;
    // zero lamps never fire, though the LFSR keeps stepping
    eval_en = 1'b1; fault_in = 4'b0001; fires0 = 0;
    repeat (10) step("t1");
    fault_in = '0;
    repeat (3) step("t1_tail");
    checks++;
    assert (fires0 == 0) else begin errors++; $error("FAIL t1_fires got=%0d expected=0", fires0); end
    lamps = 16'hFFFF; fault_in = 4'b0001;
    step("t2_trig");
    fault_in = '0;
    repeat (4) step("t2");
    lamps = 16'h0003; fault_in = 4'b0001; fires0 = 0;
    repeat (4095) step("t3");
    fault_in = '0;
    repeat (3) step("t3_tail");
    checks++;
    assert (fires0 == 2047) else begin errors++; $error("FAIL t3_fires got=%0d expected=2047", fires0); end
    eval_en = 1'b0; lamps = 16'hFFFF; fault_in = 4'b0001;
    repeat (5) step("t4_fill");
    fault_in = '0; eval_en = 1'b1; fires0 = 0;
    repeat (5) step("t4_drain");
    checks++;
    assert (fires0 == 3) else begin errors++; $error("FAIL t4_fires got=%0d expected=3", fires0); end
    eval_en = 1'b0; fault_in = 4'b0001;
    repeat (2) step("t5_fill");
    logic_reset = 1'b1; eval_en = 1'b1;
    step("t5_lreset");
    logic_reset = 1'b0; eval_en = 1'b0; fault_in = 4'b0101;
    repeat (2) step("t5_refill");
    #3 reset = 1'b1;
    #1 model_reset();
    check("t5_async");
    #2 reset = 1'b0;
    fault_in = '0;
    step("t5_post");
    lamps = 16'hFFFF; eval_en = 1'b1; fault_in = 4'b0101;
    step("t6_trig");
    fault_in = '0;
    repeat (3) step("t6");
    for (int n = 0; n < 800; n++) begin
      lamps = 16'($urandom);
      fault_in = 4'($urandom);
      eval_en = ($urandom_range(0, 9) < 7);
      logic_reset = ($urandom_range(0, 31) == 0);
      step("rand");
    end
    logic_reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
